// File: rtl/dutys_vpath_loader.sv
// Write-side driver for the duty-setting voltage path: accepts a target code,
// slews toward it in bounded steps and pulses the path load enable per step.
module dutys_vpath_loader #(
   parameter int WIDTH = 12,
   parameter int STEP  = 16,
   parameter int HOLD  = 4,
   parameter int PIPE  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] target_i,
   input  logic             target_valid_i,
   output logic             target_ready_o,
   output logic [WIDTH-1:0] dout_o,
   output logic             en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] current_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam int CNT_MAX = (PIPE > HOLD) ? PIPE : HOLD;
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   state_t           state_q;
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] current_q;
   logic [WIDTH-1:0] target_q;
   logic [CW-1:0]    cnt_q;
   logic             en_q;
   logic             done_q;
   logic             done_pend_q;
   logic [WIDTH-1:0] next_code_d;
   logic             do_step_d;

   // Move at most STEP codes toward the target; the clamp to diff prevents overshoot and wrap.
   function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] tgt);
      logic [WIDTH-1:0] diff;
      logic [WIDTH-1:0] delta;
      diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
      if ((STEP == 0) || (32'(diff) <= 32'(STEP))) begin
         delta = diff;
      end else begin
         delta = WIDTH'(STEP);
      end
      return (tgt >= cur) ? (cur + delta) : (cur - delta);
   endfunction

   assign next_code_d = step_toward(current_q, target_q);

   // A new code is issued from STEP, from the end of the EN cycle when HOLD is zero,
   // or on the last HOLD cycle.
   always_comb begin
      do_step_d = 1'b0;
      do_step_d = (state_q == S_STEP)
                | ((state_q == S_WAIT) && (cnt_q == CW'(0)) && (current_q != target_q) && (HOLD == 0))
                | ((state_q == S_HOLD) && (cnt_q == CW'(1)));
   end

   // Slew FSM with registered path outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         dout_q      <= '0;
         current_q   <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         en_q        <= 1'b0;
         done_q      <= 1'b0;
         done_pend_q <= 1'b0;
      end else begin
         en_q        <= 1'b0;
         done_q      <= done_pend_q;
         done_pend_q <= 1'b0;
         if (do_step_d) begin
            dout_q    <= next_code_d;
            current_q <= next_code_d;
            cnt_q     <= CW'(PIPE);
            en_q      <= (PIPE == 0);
            state_q   <= S_WAIT;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (target_valid_i) begin
                     target_q <= target_i;
                     if (target_i == current_q) begin
                        done_pend_q <= 1'b1;
                     end else begin
                        state_q <= S_STEP;
                     end
                  end
               end
               S_WAIT: begin
                  if (cnt_q == CW'(0)) begin
                     // EN cycle is ending: finish or rest before the next step.
                     if (current_q == target_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                     end else begin
                        cnt_q   <= CW'(HOLD);
                        state_q <= S_HOLD;
                     end
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                     en_q  <= (cnt_q == CW'(1));
                  end
               end
               S_HOLD: begin
                  cnt_q <= cnt_q - CW'(1);
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign target_ready_o = (state_q == S_IDLE) & ~rst_i;
   assign busy_o         = (state_q != S_IDLE);
   assign dout_o         = dout_q;
   assign en_o           = en_q;
   assign done_o         = done_q;
   assign current_o      = current_q;

endmodule
